alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 26 ++
 rtl/alu_mc_iter.sv | 67 ++++++
 rtl/alu_mc.sv | 117 +++++++++++
 tb/tb_alu_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: widths, opcodes, FSM states.
package alu_mc_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OPRN_WIDTH = 6;

    // Opcodes are held 32 bits wide; the top zero-extends OPRN before decode,
    // so any set upper opcode bit lands in the illegal-opcode default.
    localparam logic [31:0] OP_ADD  = 32'h01;
    localparam logic [31:0] OP_SUB  = 32'h02;
    localparam logic [31:0] OP_MULU = 32'h03;
    localparam logic [31:0] OP_SHR  = 32'h04;
    localparam logic [31:0] OP_SHL  = 32'h05;
    localparam logic [31:0] OP_AND  = 32'h06;
    localparam logic [31:0] OP_OR   = 32'h07;
    localparam logic [31:0] OP_NOR  = 32'h08;
    localparam logic [31:0] OP_SLTU = 32'h09;
    localparam logic [31:0] OP_SLT  = 32'h0A;
    localparam logic [31:0] OP_DIVU = 32'h0B;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiply and restoring divide.
// Both operations share one {hi,lo} accumulator pair and a bit counter.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int DW = ALU_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,    // capture operands, arm counter
    input  logic          is_div,
    input  logic          step,    // one bit of work this cycle
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          last,    // this step finishes the operation
    output logic [DW-1:0] res_lo,  // product low / quotient after this step
    output logic [DW-1:0] res_hi   // product high / remainder after this step
);
    localparam int CW = $clog2(DW);

    logic [DW-1:0] hi, lo, dvs;
    logic [CW-1:0] cnt;
    logic          div;
    logic [DW:0]   sum, sh, diff;
    logic [DW-1:0] nhi, nlo;

    // Next accumulator value for one multiply or divide bit.
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        sh   = {hi, lo[DW-1]};
        diff = sh - {1'b0, dvs};
        if (div) begin
            // Remainder stays below the divisor, so diff[DW] is the borrow.
            nhi = diff[DW] ? sh[DW-1:0] : diff[DW-1:0];
            nlo = {lo[DW-2:0], ~diff[DW]};
        end else begin
            nhi = sum[DW:1];
            nlo = {sum[0], lo[DW-1:1]};
        end
    end

    assign last   = step && (cnt == '0);
    assign res_lo = nlo;
    assign res_hi = nhi;

    // Accumulator, divisor/multiplicand and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            dvs <= '0;
            div <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            dvs <= b;
            div <= is_div;
            cnt <= CW'(DW - 1);
        end else if (step) begin
            hi <= nhi;
            lo <= nlo;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops decoded combinationally and registered;
// mulu/divu handed to alu_mc_iter for DATA_WIDTH cycles.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int OPRN_WIDTH = ALU_OPRN_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic [DATA_WIDTH-1:0] OUT_HI,
    output logic                  ZERO,
    output logic                  ERR,
    output logic                  BUSY,
    output logic                  DONE
);
    state_e                state_q, state_d;
    logic [31:0]           op;
    logic [DATA_WIDTH-1:0] s_lo, s_hi, i_lo, i_hi;
    logic                  s_err, iter_op, accept, single_done, iter_start, iter_last;

    assign op          = 32'(OPRN);
    assign accept      = (state_q == IDLE) && START;
    assign single_done = accept && !iter_op;
    assign iter_start  = accept && iter_op;
    assign BUSY        = (state_q == ITER);

    // Opcode decode and single-cycle results.
    always_comb begin
        s_lo    = '0;
        s_hi    = '0;
        s_err   = 1'b0;
        iter_op = 1'b0;
        case (op)
            OP_ADD:  s_lo = OP1 + OP2;
            OP_SUB:  s_lo = OP1 - OP2;
            OP_MULU: iter_op = 1'b1;
            OP_SHR:  s_lo = OP1 >> OP2;
            OP_SHL:  s_lo = OP1 << OP2;
            OP_AND:  s_lo = OP1 & OP2;
            OP_OR:   s_lo = OP1 | OP2;
            OP_NOR:  s_lo = ~(OP1 | OP2);
            OP_SLTU: s_lo = DATA_WIDTH'(OP1 < OP2);
            OP_SLT:  s_lo = DATA_WIDTH'($signed(OP1) < $signed(OP2));
            OP_DIVU: begin
                // Divide by zero never enters the iterative path.
                if (OP2 == '0) begin
                    s_lo  = '1;
                    s_hi  = OP1;
                    s_err = 1'b1;
                end else begin
                    iter_op = 1'b1;
                end
            end
            default: s_err = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (iter_start) state_d = ITER;
            ITER: if (iter_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    alu_mc_iter #(.DW(DATA_WIDTH)) u_iter (
        .clk    (CLK),
        .rst    (RST),
        .load   (iter_start),
        .is_div (op == OP_DIVU),
        .step   (BUSY),
        .a      (OP1),
        .b      (OP2),
        .last   (iter_last),
        .res_lo (i_lo),
        .res_hi (i_hi)
    );

    // Result registers: written only on completion, held otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT    <= '0;
            OUT_HI <= '0;
            ZERO   <= 1'b1;
            ERR    <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= single_done || iter_last;
            if (single_done) begin
                OUT    <= s_lo;
                OUT_HI <= s_hi;
                ZERO   <= (s_lo == '0);
                ERR    <= s_err;
            end else if (iter_last) begin
                OUT    <= i_lo;
                OUT_HI <= i_hi;
                ZERO   <= (i_lo == '0);
                ERR    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: transaction-level reference model checked
// every cycle, plus literal expectations for well-known cases.
module tb_alu_mc;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST, START;
    logic [5:0]    OPRN;
    logic [DW-1:0] OP1, OP2, OUT, OUT_HI;
    logic          ZERO, ERR, BUSY, DONE;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state (expected DUT outputs after the latest edge).
    logic [DW-1:0] m_out, m_hi, p_lo, p_hi;
    bit            m_zero, m_err, m_busy, m_done, p_err;
    int            m_rem = 0;

    alu_mc #(.DATA_WIDTH(DW), .OPRN_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
        .OUT(OUT), .OUT_HI(OUT_HI), .ZERO(ZERO), .ERR(ERR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from the opcode table.
    task automatic model_op(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [DW-1:0] lo, output logic [DW-1:0] hi,
                            output bit err, output bit iter);
        logic [63:0] p;
        lo = '0; hi = '0; err = 1'b0; iter = 1'b0;
        case (op)
            6'h01: lo = a + b;
            6'h02: lo = a - b;
            6'h03: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; iter = 1'b1; end
            6'h04: lo = (b >= DW) ? '0 : (a >> b);
            6'h05: lo = (b >= DW) ? '0 : (a << b);
            6'h06: lo = a & b;
            6'h07: lo = a | b;
            6'h08: lo = ~(a | b);
            6'h09: lo = (a < b) ? 1 : 0;
            6'h0A: lo = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h0B: if (b == 0) begin lo = '1; hi = a; err = 1'b1; end
                   else begin lo = a / b; hi = a % b; iter = 1'b1; end
            default: err = 1'b1;
        endcase
    endtask

    // Reference model: a pending iterative result matures DW edges after acceptance.
    initial forever begin
        logic [DW-1:0] lo, hi;
        bit e, it;
        @(posedge CLK);
        if (RST) begin
            m_rem = 0; m_out = '0; m_hi = '0; m_zero = 1; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_out = p_lo; m_hi = p_hi; m_err = p_err; m_zero = (p_lo == 0); m_done = 1;
                end
            end else if (START) begin
                model_op(OPRN, OP1, OP2, lo, hi, e, it);
                if (it) begin
                    m_rem = DW; p_lo = lo; p_hi = hi; p_err = e;
                end else begin
                    m_out = lo; m_hi = hi; m_err = e; m_zero = (lo == 0); m_done = 1;
                end
            end
        end
        m_busy = (m_rem > 0);
    end

    // Compare every output against the model, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("busy",   BUSY,   m_busy);
            chk("done",   DONE,   m_done);
            chk("out",    OUT,    m_out);
            chk("out_hi", OUT_HI, m_hi);
            chk("zero",   ZERO,   m_zero);
            chk("err",    ERR,    m_err);
        end
    end

    // Issue one request; returns the number of negedges until DONE is seen.
    // While busy, START and operands are scrambled to show they are ignored.
    task automatic run(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int lat);
        OPRN = op; OP1 = a; OP2 = b; START = 1'b1;
        @(negedge CLK);
        lat = 1;
        START = 1'b0;
        while (!DONE && lat < 100) begin
            START = 1'($urandom_range(0, 1));
            OPRN = 6'($urandom); OP1 = $urandom; OP2 = $urandom;
            @(negedge CLK);
            lat++;
        end
        START = 1'b0;
        chk("done_seen", DONE, 1);
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return DW'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [5:0] op;
        RST = 1'b1; START = 1'b0; OPRN = '0; OP1 = '0; OP2 = '0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_out", OUT, 0);
        chk("rst_zero", ZERO, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        RST = 1'b0;

        // Wrap-around add, single cycle.
        run(6'h01, 32'hFFFF_FFFF, 32'h1, lat);
        chk("add_lat", lat, 1);
        chk("add_out", OUT, 0);
        chk("add_zero", ZERO, 1);
        chk("add_err", ERR, 0);

        // Full product; DONE seen at the negedge after edge N+32.
        run(6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("mulu_lat", lat, DW + 1);
        chk("mulu_hi", OUT_HI, 32'hFFFF_FFFE);
        chk("mulu_lo", OUT, 32'h1);

        run(6'h0B, 32'd100, 32'd7, lat);
        chk("divu_lat", lat, DW + 1);
        chk("divu_q", OUT, 14);
        chk("divu_r", OUT_HI, 2);

        run(6'h0B, 32'd5, 32'd0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_q", OUT, 32'hFFFF_FFFF);
        chk("div0_r", OUT_HI, 5);
        chk("div0_err", ERR, 1);

        run(6'h0A, 32'hFFFF_FFFF, 32'h1, lat);
        chk("slt_out", OUT, 1);
        run(6'h09, 32'hFFFF_FFFF, 32'h1, lat);
        chk("sltu_out", OUT, 0);
        run(6'h05, 32'h1, 32'd40, lat);
        chk("shl40_out", OUT, 0);

        // Reset in the middle of a multiply: no DONE, outputs cleared.
        OPRN = 6'h03; OP1 = 32'd1234; OP2 = 32'd5678; START = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            START = 1'($urandom_range(0, 1)); OP1 = $urandom; OP2 = $urandom;
            @(negedge CLK);
        end
        START = 1'b1; RST = 1'b1;
        @(negedge CLK);
        chk("abort_done", DONE, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_out", OUT, 0);
        chk("abort_zero", ZERO, 1);
        RST = 1'b0; START = 1'b0;
        run(6'h01, 32'd2, 32'd3, lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_out", OUT, 5);

        // Back-to-back: each run starts on the negedge where DONE is high.
        run(6'h03, 32'd3, 32'd5, lat);
        chk("b2b_mul", OUT, 15);
        run(6'h0B, 32'd50, 32'd6, lat);
        chk("b2b_div_lat", lat, DW + 1);
        chk("b2b_div_q", OUT, 8);
        chk("b2b_div_r", OUT_HI, 2);
        run(6'h3F, 32'd9, 32'd9, lat);
        chk("ill_err", ERR, 1);
        chk("ill_out", OUT, 0);
        chk("ill_zero", ZERO, 1);

        // Randomized operations against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 15);
            op = (r <= 11) ? 6'(r) : 6'($urandom_range(12, 63));
            run(op, pick_operand(), pick_operand(), lat);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
